// File: rtl/pump_ctrl_robust.sv
//==============================================================================
// Module      : pump_ctrl_robust (with helper pump_ctrl_debounce)
// Description : Two-tank transfer-pump controller. Synchronises and debounces
//               the raw level sensors and auto-enable switch, checks level
//               plausibility, and runs an IDLE/PUMPING/FAULT state machine
//               driving the pump, inlet solenoid and status LEDs. Faults latch
//               until rst_n is asserted.
//               Optional macro PUMP_SIM_FAST_DEBOUNCE_EN switches the debounce
//               time base from milliseconds to microseconds for simulation.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

// Per-channel input conditioning: 2-FF synchroniser, stability debouncer and
// step-size plausibility check on every debounced update.
module pump_ctrl_debounce #(
  parameter int W         = 3,
  parameter int DB_CYCLES = 2,
  parameter int MAX_STEP  = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] raw,
  output logic [W-1:0] db,
  output logic         step_err
);

  localparam int            CW     = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] C_LAST = CW'(DB_CYCLES - 1);
  localparam logic [7:0]    C_MAX  = 8'(MAX_STEP);

  logic [W-1:0]  r_sync1;
  logic [W-1:0]  r_sync2;
  logic [W-1:0]  r_db;
  logic [CW-1:0] r_cnt;
  logic          r_armed;
  logic          r_step_err;

  logic          w_upd;
  logic [7:0]    w_new;
  logic [7:0]    w_old;
  logic [7:0]    w_diff;

  // The synchronised value has held DB_CYCLES clocks and differs from the
  // debounced copy: it is accepted on this edge.
  assign w_upd  = (r_sync2 != r_db) && (r_cnt == C_LAST);
  assign w_new  = 8'(r_sync2);
  assign w_old  = 8'(r_db);
  assign w_diff = (w_new >= w_old) ? (w_new - w_old) : (w_old - w_new);

  // Two-stage synchroniser for the asynchronous board input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
    end
  end

  // Stability counter: restarts whenever the synchronised value is about to
  // change or already matches the debounced value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if ((r_sync1 != r_sync2) || (r_sync2 == r_db)) begin
      r_cnt <= '0;
    end else if (r_cnt != C_LAST) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Debounced value, plus a one-clock step error that is only armed once the
  // channel has seen its first accepted value since reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_db       <= '0;
      r_armed    <= 1'b0;
      r_step_err <= 1'b0;
    end else begin
      r_step_err <= w_upd && r_armed && (w_diff > C_MAX);
      if (w_upd) begin
        r_db    <= r_sync2;
        r_armed <= 1'b1;
      end
    end
  end

  assign db       = r_db;
  assign step_err = r_step_err;

endmodule

module pump_ctrl_robust #(
  parameter int CLK_HZ      = 100_000_000,
  parameter int DEBOUNCE_MS = 10,
  parameter int MAX_STEP    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] lvl_inf_raw,
  input  logic [2:0] lvl_sup_raw,
  input  logic       en_auto_raw,
  output logic       pump_on,
  output logic       solenoid_open,
  output logic       led_green,
  output logic       led_red,
  output logic       fault_latched
);

`ifdef PUMP_SIM_FAST_DEBOUNCE_EN
  // Microsecond time base, never shorter than two clocks.
  localparam int C_DB_RAW  = DEBOUNCE_MS * (CLK_HZ / 1_000_000);
  localparam int DB_CYCLES = (C_DB_RAW < 2) ? 2 : C_DB_RAW;
`else
  // Millisecond time base; clamped to one clock for very slow clocks.
  localparam int C_DB_RAW  = DEBOUNCE_MS * (CLK_HZ / 1000);
  localparam int DB_CYCLES = (C_DB_RAW < 1) ? 1 : C_DB_RAW;
`endif

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PUMPING = 2'd1,
    S_FAULT   = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;

  logic [2:0] w_inf;
  logic [2:0] w_sup;
  logic       w_en;
  logic       w_err_inf;
  logic       w_err_sup;
  logic       w_err_en;
  logic       w_invalid;
  logic       w_fault_any;

  logic       r_run;
  logic       r_fault;

  pump_ctrl_debounce #(.W(3), .DB_CYCLES(DB_CYCLES), .MAX_STEP(MAX_STEP)) u_db_inf (
    .clk      (clk),
    .rst_n    (rst_n),
    .raw      (lvl_inf_raw),
    .db       (w_inf),
    .step_err (w_err_inf)
  );

  pump_ctrl_debounce #(.W(3), .DB_CYCLES(DB_CYCLES), .MAX_STEP(MAX_STEP)) u_db_sup (
    .clk      (clk),
    .rst_n    (rst_n),
    .raw      (lvl_sup_raw),
    .db       (w_sup),
    .step_err (w_err_sup)
  );

  // A 1-bit switch can never step by more than one, so its step error stays
  // low; it is folded in only so the channel logic is uniform.
  pump_ctrl_debounce #(.W(1), .DB_CYCLES(DB_CYCLES), .MAX_STEP(MAX_STEP)) u_db_en (
    .clk      (clk),
    .rst_n    (rst_n),
    .raw      (en_auto_raw),
    .db       (w_en),
    .step_err (w_err_en)
  );

  assign w_invalid   = (w_inf > 3'd4) || (w_sup > 3'd4);
  assign w_fault_any = w_invalid || w_err_inf || w_err_sup || w_err_en;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic, priority fault > stop > start.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_fault_any) begin
          w_state_nxt = S_FAULT;
        end else if (w_en && (w_inf >= 3'd3) && (w_sup <= 3'd1)) begin
          w_state_nxt = S_PUMPING;
        end
      end
      S_PUMPING: begin
        if (w_fault_any || (w_inf == 3'd0) || (w_sup == 3'd4)) begin
          w_state_nxt = S_FAULT;
        end else if ((w_sup >= 3'd3) || !w_en) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_FAULT: begin
        w_state_nxt = S_FAULT;
      end
      default: begin
        w_state_nxt = S_FAULT;
      end
    endcase
  end

  // Registered output decode; async reset drops the drives immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run   <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_run   <= (r_state == S_PUMPING);
      r_fault <= (r_state == S_FAULT);
    end
  end

  assign pump_on       = r_run;
  assign solenoid_open = r_run;
  assign led_green     = r_run;
  assign led_red       = r_fault;
  assign fault_latched = r_fault;

endmodule

`default_nettype wire

// File: tb/tb_pump_ctrl_robust.sv
//==============================================================================
// Module      : tb_pump_ctrl_robust
// Description : Self-checking bench for pump_ctrl_robust. Two instances share
//               the stimulus: one with MAX_STEP=3, one with MAX_STEP=1. An
//               event-level reference model tracks debounced values and the
//               controller mode for each instance.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_pump_ctrl_robust;

  // Both time bases resolve to a 100-cycle debounce with these clocks.
`ifdef PUMP_SIM_FAST_DEBOUNCE_EN
  localparam int TB_CLK_HZ = 100_000_000;
`else
  localparam int TB_CLK_HZ = 100_000;
`endif

  localparam int M_IDLE  = 0;
  localparam int M_PUMP  = 1;
  localparam int M_FAULT = 2;

  logic       clk;
  logic       rst_n;
  logic [2:0] lvl_inf_raw;
  logic [2:0] lvl_sup_raw;
  logic       en_auto_raw;

  logic pump_a, sol_a, grn_a, red_a, flt_a;
  logic pump_b, sol_b, grn_b, red_b, flt_b;
  logic [4:0] obs_a;
  logic [4:0] obs_b;

  int checks;
  int errors;

  // Reference model state, index 0 = MAX_STEP 3, index 1 = MAX_STEP 1.
  int         m_st   [2];
  int         m_step [2];
  logic [2:0] m_inf  [2];
  logic [2:0] m_sup  [2];
  logic       m_en   [2];
  bit         m_ai   [2];
  bit         m_as   [2];

  assign obs_a = {pump_a, sol_a, grn_a, red_a, flt_a};
  assign obs_b = {pump_b, sol_b, grn_b, red_b, flt_b};

  pump_ctrl_robust #(.CLK_HZ(TB_CLK_HZ), .DEBOUNCE_MS(1), .MAX_STEP(3)) dut_a (
    .clk           (clk),
    .rst_n         (rst_n),
    .lvl_inf_raw   (lvl_inf_raw),
    .lvl_sup_raw   (lvl_sup_raw),
    .en_auto_raw   (en_auto_raw),
    .pump_on       (pump_a),
    .solenoid_open (sol_a),
    .led_green     (grn_a),
    .led_red       (red_a),
    .fault_latched (flt_a)
  );

  pump_ctrl_robust #(.CLK_HZ(TB_CLK_HZ), .DEBOUNCE_MS(1), .MAX_STEP(1)) dut_b (
    .clk           (clk),
    .rst_n         (rst_n),
    .lvl_inf_raw   (lvl_inf_raw),
    .lvl_sup_raw   (lvl_sup_raw),
    .en_auto_raw   (en_auto_raw),
    .pump_on       (pump_b),
    .solenoid_open (sol_b),
    .led_green     (grn_b),
    .led_red       (red_b),
    .fault_latched (flt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  // Expected {pump, solenoid, green, red, fault} for a model instance.
  function automatic logic [4:0] exp_vec(input int k);
    logic p;
    logic f;
    p = (m_st[k] == M_PUMP);
    f = (m_st[k] == M_FAULT);
    return {p, p, p, f, f};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k]  = M_IDLE;
      m_inf[k] = 3'd0;
      m_sup[k] = 3'd0;
      m_en[k]  = 1'b0;
      m_ai[k]  = 1'b0;
      m_as[k]  = 1'b0;
    end
  endtask

  // Apply a settled set of inputs to the model: debounced updates with step
  // checks, invalid-code detection, then one controller decision.
  task automatic model_apply(input int k, input logic [2:0] inf, input logic [2:0] sup,
                             input logic en);
    bit f;
    f = 1'b0;
    if (inf != m_inf[k]) begin
      if (m_ai[k] && absd(int'(inf), int'(m_inf[k])) > m_step[k]) f = 1'b1;
      m_ai[k]  = 1'b1;
      m_inf[k] = inf;
    end
    if (sup != m_sup[k]) begin
      if (m_as[k] && absd(int'(sup), int'(m_sup[k])) > m_step[k]) f = 1'b1;
      m_as[k]  = 1'b1;
      m_sup[k] = sup;
    end
    m_en[k] = en;
    if (m_inf[k] > 3'd4 || m_sup[k] > 3'd4) f = 1'b1;
    if (m_st[k] != M_FAULT) begin
      if (f) begin
        m_st[k] = M_FAULT;
      end else if (m_st[k] == M_IDLE) begin
        if (m_en[k] && m_inf[k] >= 3'd3 && m_sup[k] <= 3'd1) m_st[k] = M_PUMP;
      end else begin
        if (m_inf[k] == 3'd0 || m_sup[k] == 3'd4) m_st[k] = M_FAULT;
        else if (m_sup[k] >= 3'd3 || !m_en[k]) m_st[k] = M_IDLE;
      end
    end
  endtask

  // Drive new raw inputs, sample outputs 90 clocks later (still inside the
  // debounce window) and again after the full latency, then update the model.
  task automatic settle(input logic [2:0] inf, input logic [2:0] sup, input logic en,
                        output logic [4:0] mid_a, output logic [4:0] mid_b);
    lvl_inf_raw = inf;
    lvl_sup_raw = sup;
    en_auto_raw = en;
    repeat (90) @(posedge clk);
    #1;
    mid_a = obs_a;
    mid_b = obs_b;
    repeat (20) @(posedge clk);
    #1;
    model_apply(0, inf, sup, en);
    model_apply(1, inf, sup, en);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    lvl_inf_raw = 3'd0;
    lvl_sup_raw = 3'd0;
    en_auto_raw = 1'b0;
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (obs_a !== 5'b0 || obs_b !== 5'b0) begin
      errors++;
      $display("FAIL reset_state: got a=%b b=%b, want 00000", obs_a, obs_b);
    end
    rst_n = 1'b1;
    model_reset();
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (obs_a !== 5'b0 || obs_b !== 5'b0) begin
      errors++;
      $display("FAIL reset_idle: got a=%b b=%b, want 00000", obs_a, obs_b);
    end
  endtask

  task automatic test_start();
    logic [4:0] mid_a, mid_b;
    settle(3'd3, 3'd1, 1'b1, mid_a, mid_b);
    checks++;
    if (mid_a !== 5'b0 || mid_b !== 5'b0) begin
      errors++;
      $display("FAIL start_latency90: got a=%b b=%b, want 00000", mid_a, mid_b);
    end
    checks++;
    if (obs_a !== 5'b11100 || obs_a !== exp_vec(0)) begin
      errors++;
      $display("FAIL start_pumping_a: got %b, want 11100", obs_a);
    end
    checks++;
    if (obs_b !== exp_vec(1)) begin
      errors++;
      $display("FAIL start_pumping_b: got %b, want %b", obs_b, exp_vec(1));
    end
  endtask

  task automatic test_stop_restart();
    logic [4:0] mid_a, mid_b;
    logic [4:0] pre_a;
    pre_a = exp_vec(0);
    settle(3'd3, 3'd3, 1'b1, mid_a, mid_b);
    checks++;
    if (mid_a !== pre_a) begin
      errors++;
      $display("FAIL stop_latency90: got %b, want %b", mid_a, pre_a);
    end
    checks++;
    if (obs_a !== 5'b00000) begin
      errors++;
      $display("FAIL stop_full_a: got %b, want 00000", obs_a);
    end
    checks++;
    if (obs_b !== exp_vec(1)) begin
      errors++;
      $display("FAIL stop_step_b: got %b, want %b", obs_b, exp_vec(1));
    end
    settle(3'd3, 3'd1, 1'b1, mid_a, mid_b);
    checks++;
    if (obs_a !== 5'b11100) begin
      errors++;
      $display("FAIL restart_a: got %b, want 11100", obs_a);
    end
  endtask

  task automatic test_dry_run();
    logic [4:0] mid_a, mid_b;
    settle(3'd0, 3'd1, 1'b1, mid_a, mid_b);
    checks++;
    if (obs_a !== 5'b00011 || obs_a !== exp_vec(0)) begin
      errors++;
      $display("FAIL dry_run_fault: got %b, want 00011", obs_a);
    end
    settle(3'd3, 3'd1, 1'b1, mid_a, mid_b);
    checks++;
    if (obs_a !== 5'b00011) begin
      errors++;
      $display("FAIL fault_sticky: got %b, want 00011", obs_a);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs_a !== 5'b0 || obs_b !== 5'b0) begin
      errors++;
      $display("FAIL fault_clear_reset: got a=%b b=%b, want 00000", obs_a, obs_b);
    end
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_overflow();
    logic [4:0] mid_a, mid_b;
    do_reset();
    settle(3'd3, 3'd1, 1'b1, mid_a, mid_b);
    settle(3'd3, 3'd4, 1'b1, mid_a, mid_b);
    checks++;
    if (obs_a !== 5'b00011) begin
      errors++;
      $display("FAIL overflow_fault: got %b, want 00011", obs_a);
    end
  endtask

  task automatic test_plausibility();
    logic [4:0] mid_a, mid_b;
    do_reset();
    settle(3'd3, 3'd1, 1'b1, mid_a, mid_b);
    settle(3'd1, 3'd1, 1'b1, mid_a, mid_b);
    checks++;
    if (obs_b !== 5'b00011) begin
      errors++;
      $display("FAIL step_fault_b: got %b, want 00011", obs_b);
    end
    checks++;
    if (obs_a !== 5'b11100) begin
      errors++;
      $display("FAIL step_ok_a: got %b, want 11100", obs_a);
    end
    lvl_inf_raw = 3'd0;
    lvl_sup_raw = 3'd0;
    en_auto_raw = 1'b0;
    do_reset();
    settle(3'd0, 3'd6, 1'b0, mid_a, mid_b);
    checks++;
    if (obs_a !== 5'b00011 || obs_b !== 5'b00011) begin
      errors++;
      $display("FAIL invalid_code: got a=%b b=%b, want 00011", obs_a, obs_b);
    end
  endtask

  task automatic test_glitch_enable();
    logic [4:0] mid_a, mid_b;
    lvl_inf_raw = 3'd0;
    lvl_sup_raw = 3'd0;
    en_auto_raw = 1'b0;
    do_reset();
    settle(3'd3, 3'd1, 1'b1, mid_a, mid_b);
    lvl_sup_raw = 3'd3;
    repeat (50) @(posedge clk);
    #1;
    lvl_sup_raw = 3'd1;
    repeat (120) @(posedge clk);
    #1;
    checks++;
    if (obs_a !== 5'b11100 || obs_b !== 5'b11100) begin
      errors++;
      $display("FAIL glitch_ignored: got a=%b b=%b, want 11100", obs_a, obs_b);
    end
    settle(3'd3, 3'd1, 1'b0, mid_a, mid_b);
    checks++;
    if (obs_a !== 5'b00000 || obs_b !== 5'b00000) begin
      errors++;
      $display("FAIL enable_off: got a=%b b=%b, want 00000", obs_a, obs_b);
    end
    settle(3'd3, 3'd1, 1'b1, mid_a, mid_b);
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs_a !== 5'b0) begin
      errors++;
      $display("FAIL reset_mid_pump: got %b, want 00000", obs_a);
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_random();
    logic [4:0] mid_a, mid_b;
    logic [4:0] pre_a, pre_b;
    logic [2:0] inf, sup;
    logic       en;
    for (int it = 0; it < 40; it++) begin
      if (m_st[0] == M_FAULT && m_st[1] == M_FAULT) do_reset();
      pre_a = exp_vec(0);
      pre_b = exp_vec(1);
      inf = ($urandom_range(0, 9) == 9) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      sup = ($urandom_range(0, 9) == 9) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      en  = ($urandom_range(0, 3) != 0);
      settle(inf, sup, en, mid_a, mid_b);
      checks++;
      if (mid_a !== pre_a || mid_b !== pre_b) begin
        errors++;
        $display("FAIL rand_hold it=%0d: got a=%b b=%b, want a=%b b=%b",
                 it, mid_a, mid_b, pre_a, pre_b);
      end
      checks++;
      if (obs_a !== exp_vec(0) || obs_b !== exp_vec(1)) begin
        errors++;
        $display("FAIL rand_settle it=%0d inf=%0d sup=%0d en=%0d: got a=%b b=%b, want a=%b b=%b",
                 it, inf, sup, en, obs_a, obs_b, exp_vec(0), exp_vec(1));
      end
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    m_step[0] = 3;
    m_step[1] = 1;
    model_reset();
    rst_n = 1'b0;
    #2;
    test_reset();
    test_start();
    test_stop_restart();
    test_dry_run();
    test_overflow();
    test_plausibility();
    test_glitch_enable();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
